// File: rtl/id_ex_stage_reg_pkg.sv
// Shared pipeline definitions: ALU operation classes, ID/EX control bundle
// and the bubble/reset value of that bundle.
package id_ex_stage_reg_pkg;

  localparam int unsigned FUNCT_W    = 10;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALUOP_W    = 2;

  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_LOAD_STORE = 2'b00,
    ALUOP_BRANCH     = 2'b01,
    ALUOP_RTYPE      = 2'b10,
    ALUOP_ITYPE      = 2'b11
  } aluop_e;

  typedef struct packed {
    logic   valid;
    logic   reg_write;
    logic   memto_reg;
    logic   mem_read;
    logic   mem_write;
    logic   alu_src;
    aluop_e alu_op;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  // A bubble must look exactly like a freshly reset stage to forwarding logic.
  localparam ctrl_t CTRL_BUBBLE = '{
    valid:     1'b0,
    reg_write: 1'b0,
    memto_reg: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    alu_src:   1'b0,
    alu_op:    ALUOP_LOAD_STORE
  };

endpackage

// File: rtl/id_ex_stage_reg_pipe_reg.sv
// Generic pipeline register: synchronous active-low reset, load enable,
// and a clear that loads CLR_VAL when enabled.
module pipe_reg #(
  parameter int unsigned     W       = 8,
  parameter logic [W-1:0]    CLR_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Reset overrides enable; clear only takes effect when the stage advances.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q <= CLR_VAL;
    end else if (i_en) begin
      r_q <= i_clr ? CLR_VAL : i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline stage register with stall hold, flush-to-bubble,
// x0 write suppression and a saturating bubble counter.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  Stall_i,
  input  logic                  Flush_i,
  input  logic                  Valid_i,
  input  logic                  RegWrite_i,
  input  logic                  MemtoReg_i,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  input  logic                  ALUSrc_i,
  input  logic [ALUOP_W-1:0]    ALUOp_i,
  input  logic [DATA_W-1:0]     RS1Data_i,
  input  logic [DATA_W-1:0]     RS2Data_i,
  input  logic [DATA_W-1:0]     Imm_i,
  input  logic [FUNCT_W-1:0]    Funct_i,
  input  logic [REG_ADDR_W-1:0] RS1Addr_i,
  input  logic [REG_ADDR_W-1:0] RS2Addr_i,
  input  logic [REG_ADDR_W-1:0] RDAddr_i,
  output logic                  Valid_o,
  output logic                  RegWrite_o,
  output logic                  MemtoReg_o,
  output logic                  MemRead_o,
  output logic                  MemWrite_o,
  output logic                  ALUSrc_o,
  output logic [ALUOP_W-1:0]    ALUOp_o,
  output logic [DATA_W-1:0]     RS1Data_o,
  output logic [DATA_W-1:0]     RS2Data_o,
  output logic [DATA_W-1:0]     Imm_o,
  output logic [FUNCT_W-1:0]    Funct_o,
  output logic [REG_ADDR_W-1:0] RS1Addr_o,
  output logic [REG_ADDR_W-1:0] RS2Addr_o,
  output logic [REG_ADDR_W-1:0] RDAddr_o,
  output logic [CNT_W-1:0]      BubbleCnt_o
);

  localparam int unsigned    DBUS_W  = 3 * DATA_W + FUNCT_W + 3 * REG_ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_t             w_ctrl_d;
  ctrl_t             w_ctrl_q;
  logic [DBUS_W-1:0] w_data_d;
  logic [DBUS_W-1:0] w_data_q;
  logic              w_en;
  logic              w_bubble;
  logic [CNT_W-1:0]  r_bubble_cnt;

  assign w_en     = ~Stall_i;
  assign w_bubble = ~Stall_i & Flush_i;

  // Invalid instructions carry no side effects; x0 is never a write target.
  always_comb begin
    w_ctrl_d = CTRL_BUBBLE;
    if (Valid_i) begin
      w_ctrl_d.valid     = 1'b1;
      w_ctrl_d.reg_write = RegWrite_i & (RDAddr_i != REG_ADDR_W'(0));
      w_ctrl_d.memto_reg = MemtoReg_i;
      w_ctrl_d.mem_read  = MemRead_i;
      w_ctrl_d.mem_write = MemWrite_i;
      w_ctrl_d.alu_src   = ALUSrc_i;
      w_ctrl_d.alu_op    = aluop_e'(ALUOp_i);
    end
  end

  assign w_data_d = {RS1Data_i, RS2Data_i, Imm_i, Funct_i, RS1Addr_i, RS2Addr_i, RDAddr_i};

  pipe_reg #(
    .W       (CTRL_W),
    .CLR_VAL (CTRL_BUBBLE)
  ) u_ctrl_reg (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_en    (w_en),
    .i_clr   (Flush_i),
    .i_d     (w_ctrl_d),
    .o_q     (w_ctrl_q)
  );

  pipe_reg #(
    .W       (DBUS_W),
    .CLR_VAL ('0)
  ) u_data_reg (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_en    (w_en),
    .i_clr   (Flush_i),
    .i_d     (w_data_d),
    .o_q     (w_data_q)
  );

  assign Valid_o    = w_ctrl_q.valid;
  assign RegWrite_o = w_ctrl_q.reg_write;
  assign MemtoReg_o = w_ctrl_q.memto_reg;
  assign MemRead_o  = w_ctrl_q.mem_read;
  assign MemWrite_o = w_ctrl_q.mem_write;
  assign ALUSrc_o   = w_ctrl_q.alu_src;
  assign ALUOp_o    = ALUOP_W'(w_ctrl_q.alu_op);

  assign {RS1Data_o, RS2Data_o, Imm_o, Funct_o, RS1Addr_o, RS2Addr_o, RDAddr_o} = w_data_q;

  // Counts inserted bubbles; sticks at all-ones rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != CNT_MAX)) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign BubbleCnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios followed by
// randomized traffic compared against a rule-level model of the stage.
module tb_id_ex_stage_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i, Stall_i, Flush_i, Valid_i;
  logic RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
  logic [1:0]        ALUOp_i;
  logic [DATA_W-1:0] RS1Data_i, RS2Data_i, Imm_i;
  logic [9:0]        Funct_i;
  logic [4:0]        RS1Addr_i, RS2Addr_i, RDAddr_i;

  logic Valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o;
  logic [1:0]        ALUOp_o;
  logic [DATA_W-1:0] RS1Data_o, RS2Data_o, Imm_o;
  logic [9:0]        Funct_o;
  logic [4:0]        RS1Addr_o, RS2Addr_o, RDAddr_o;
  logic [CNT_W-1:0]  BubbleCnt_o;

  id_ex_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .Stall_i(Stall_i), .Flush_i(Flush_i),
    .Valid_i(Valid_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i),
    .ALUOp_i(ALUOp_i), .RS1Data_i(RS1Data_i), .RS2Data_i(RS2Data_i),
    .Imm_i(Imm_i), .Funct_i(Funct_i), .RS1Addr_i(RS1Addr_i),
    .RS2Addr_i(RS2Addr_i), .RDAddr_i(RDAddr_i),
    .Valid_o(Valid_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o),
    .ALUOp_o(ALUOp_o), .RS1Data_o(RS1Data_o), .RS2Data_o(RS2Data_o),
    .Imm_o(Imm_o), .Funct_o(Funct_o), .RS1Addr_o(RS1Addr_o),
    .RS2Addr_o(RS2Addr_o), .RDAddr_o(RDAddr_o), .BubbleCnt_o(BubbleCnt_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Expected architectural state of the stage, indexed by field.
  typedef enum int {F_VALID, F_RW, F_M2R, F_MRD, F_MWR, F_ASRC, F_ALUOP,
                    F_RS1D, F_RS2D, F_IMM, F_FUNCT, F_RS1A, F_RS2A, F_RDA,
                    F_NUM} field_e;
  logic [63:0] exp_f [F_NUM];
  int          exp_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply the stage's rules for one rising edge to the model.
  task automatic model_edge();
    if (!rst_i) begin
      foreach (exp_f[i]) exp_f[i] = '0;
      exp_cnt = 0;
    end else if (Stall_i) begin
      // everything held
    end else if (Flush_i) begin
      foreach (exp_f[i]) exp_f[i] = '0;
      exp_cnt = (exp_cnt + 1 > 15) ? 15 : exp_cnt + 1;
    end else begin
      exp_f[F_VALID] = 64'(Valid_i);
      exp_f[F_RW]    = 64'(Valid_i && RegWrite_i && RDAddr_i != 0);
      exp_f[F_M2R]   = 64'(Valid_i && MemtoReg_i);
      exp_f[F_MRD]   = 64'(Valid_i && MemRead_i);
      exp_f[F_MWR]   = 64'(Valid_i && MemWrite_i);
      exp_f[F_ASRC]  = 64'(Valid_i && ALUSrc_i);
      exp_f[F_ALUOP] = Valid_i ? 64'(ALUOp_i) : 64'd0;
      exp_f[F_RS1D]  = 64'(RS1Data_i);
      exp_f[F_RS2D]  = 64'(RS2Data_i);
      exp_f[F_IMM]   = 64'(Imm_i);
      exp_f[F_FUNCT] = 64'(Funct_i);
      exp_f[F_RS1A]  = 64'(RS1Addr_i);
      exp_f[F_RS2A]  = 64'(RS2Addr_i);
      exp_f[F_RDA]   = 64'(RDAddr_i);
    end
  endtask

  task automatic check_all();
    check("Valid_o",     64'(Valid_o),     exp_f[F_VALID]);
    check("RegWrite_o",  64'(RegWrite_o),  exp_f[F_RW]);
    check("MemtoReg_o",  64'(MemtoReg_o),  exp_f[F_M2R]);
    check("MemRead_o",   64'(MemRead_o),   exp_f[F_MRD]);
    check("MemWrite_o",  64'(MemWrite_o),  exp_f[F_MWR]);
    check("ALUSrc_o",    64'(ALUSrc_o),    exp_f[F_ASRC]);
    check("ALUOp_o",     64'(ALUOp_o),     exp_f[F_ALUOP]);
    check("RS1Data_o",   64'(RS1Data_o),   exp_f[F_RS1D]);
    check("RS2Data_o",   64'(RS2Data_o),   exp_f[F_RS2D]);
    check("Imm_o",       64'(Imm_o),       exp_f[F_IMM]);
    check("Funct_o",     64'(Funct_o),     exp_f[F_FUNCT]);
    check("RS1Addr_o",   64'(RS1Addr_o),   exp_f[F_RS1A]);
    check("RS2Addr_o",   64'(RS2Addr_o),   exp_f[F_RS2A]);
    check("RDAddr_o",    64'(RDAddr_o),    exp_f[F_RDA]);
    check("BubbleCnt_o", 64'(BubbleCnt_o), 64'(exp_cnt));
  endtask

  // One clock: inputs already set; update model at the edge, compare at negedge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_payload();
    Valid_i    = 1'b1;
    RegWrite_i = 1'($urandom);
    MemtoReg_i = 1'($urandom);
    MemRead_i  = 1'($urandom);
    MemWrite_i = 1'($urandom);
    ALUSrc_i   = 1'($urandom);
    ALUOp_i    = 2'($urandom);
    RS1Data_i  = $urandom;
    RS2Data_i  = $urandom;
    Imm_i      = $urandom;
    Funct_i    = 10'($urandom);
    RS1Addr_i  = 5'($urandom);
    RS2Addr_i  = 5'($urandom);
    RDAddr_i   = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
  endtask

  initial begin
    foreach (exp_f[i]) exp_f[i] = '0;
    exp_cnt = 0;
    rand_payload();

    // Reset overrides concurrent stall and flush.
    rst_i = 1'b0; Stall_i = 1'b1; Flush_i = 1'b1;
    tick();
    check("rst_bubblecnt", 64'(BubbleCnt_o), 64'd0);
    check("rst_valid", 64'(Valid_o), 64'd0);

    // Plain load.
    rst_i = 1'b1; Stall_i = 1'b0; Flush_i = 1'b0;
    rand_payload();
    RegWrite_i = 1'b1; RDAddr_i = 5'd5; RS1Data_i = 32'h0000_1234;
    tick();
    check("load_rw", 64'(RegWrite_o), 64'd1);
    check("load_rd", 64'(RDAddr_o), 64'd5);
    check("load_rs1", 64'(RS1Data_o), 64'h1234);
    check("load_valid", 64'(Valid_o), 64'd1);

    // Writes to x0 are suppressed but the index is still carried.
    rand_payload();
    RegWrite_i = 1'b1; RDAddr_i = 5'd0;
    tick();
    check("x0_rw", 64'(RegWrite_o), 64'd0);
    check("x0_valid", 64'(Valid_o), 64'd1);

    // Stall with pending flush holds contents; flush applies once stall drops.
    rand_payload();
    RS2Data_i = 32'hDEAD_BEEF;
    tick();
    Stall_i = 1'b1; Flush_i = 1'b1;
    rand_payload();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_rs2", 64'(RS2Data_o), 64'hDEAD_BEEF);
      check("stall_cnt", 64'(BubbleCnt_o), 64'd0);
    end
    Stall_i = 1'b0;
    tick();
    check("flush_rs2", 64'(RS2Data_o), 64'd0);
    check("flush_cnt", 64'(BubbleCnt_o), 64'd1);

    // Invalid instruction drops all control side effects, no bubble counted.
    Flush_i = 1'b0;
    rand_payload();
    Valid_i = 1'b0; MemWrite_i = 1'b1;
    tick();
    check("inval_mwr", 64'(MemWrite_o), 64'd0);
    check("inval_valid", 64'(Valid_o), 64'd0);
    check("inval_cnt", 64'(BubbleCnt_o), 64'd1);

    // Flush with an invalid instruction is still a counted bubble.
    Flush_i = 1'b1;
    tick();
    check("flush_inval_cnt", 64'(BubbleCnt_o), 64'd2);

    // Saturation: 17 consecutive flushes after reset.
    rst_i = 1'b0; Flush_i = 1'b0;
    tick();
    rst_i = 1'b1; Flush_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rand_payload();
      tick();
    end
    check("sat_cnt", 64'(BubbleCnt_o), 64'hF);
    tick();
    check("sat_hold", 64'(BubbleCnt_o), 64'hF);

    // Reset in the middle of a stall discards held contents.
    Flush_i = 1'b0;
    rand_payload();
    tick();
    Stall_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
    check("rst_in_stall_rs1", 64'(RS1Data_o), 64'd0);
    rst_i = 1'b1; Stall_i = 1'b0;

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      rand_payload();
      Valid_i = ($urandom_range(0, 4) != 0);
      rst_i   = ($urandom_range(0, 24) != 0);
      Stall_i = ($urandom_range(0, 3) == 0);
      Flush_i = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout no completion (t=%0t)", $time);
    $fatal(1);
  end

endmodule

// File: doc/id_ex_stage_reg.md
ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/immediate width.
REQ-002 SHALL have parameter CNT_W, default 16, bubble-counter width.
REQ-003 SHALL have clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst_i  input  1  reset, synchronous, active-low.
REQ-005 SHALL have Stall_i  input  1  hold all state (cache/memory stall).
REQ-006 SHALL have Flush_i  input  1  load a bubble instead of ID contents (load-use hazard or taken branch).
REQ-007 SHALL have Valid_i  input  1  ID stage holds a real instruction.
REQ-008 SHALL have RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i  input  1 each  ID control bits.
REQ-009 SHALL have ALUOp_i  input  2  ALU operation class.
REQ-010 SHALL have RS1Data_i, RS2Data_i, Imm_i  input  DATA_W each  register-file reads and sign-extended immediate.
REQ-011 SHALL have Funct_i  input  10  {funct7, funct3}.
REQ-012 SHALL have RS1Addr_i, RS2Addr_i, RDAddr_i  input  5 each  register indices.
REQ-013 SHALL have one registered output <name>_o of identical width for every input of REQ-007..REQ-012.
REQ-014 SHALL have BubbleCnt_o  output  CNT_W  count of bubbles inserted by Flush_i.

Function
REQ-015 SHALL present registered values only; latency one cycle, no combinational input-to-output path.
REQ-016 SHALL apply per-edge priority: reset > Stall_i > Flush_i > normal load.
REQ-017 SHALL, on normal load (Stall_i=0, Flush_i=0), capture every input into its matching output.
REQ-018 SHALL force RegWrite_o=0 on load when RDAddr_i=0 (x0 never written/forwarded); RDAddr_o still captures 0.
REQ-019 SHALL force all control outputs and Valid_o to 0 on load when Valid_i=0.
REQ-020 SHALL, on Stall_i=1, hold every output and BubbleCnt_o unchanged, regardless of Flush_i (upstream holds Flush_i until stall clears).
REQ-021 SHALL, on Flush_i=1 with Stall_i=0, load a bubble: Valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o = 0; ALUOp_o=0; all data, Funct and address outputs = 0.
REQ-022 SHALL increment BubbleCnt_o by 1 on each bubble load of REQ-021, saturating at all-ones (no wrap).
REQ-023 SHALL make bubble outputs indistinguishable from reset outputs, so downstream forwarding sees RDAddr_o=0, RegWrite_o=0.
REQ-024 SHALL treat Flush_i=1 with Valid_i=0 identically to REQ-021 (bubble counted).

Reset
REQ-025 SHALL, on rising clk_i with rst_i=0, clear every output including BubbleCnt_o to 0, overriding Stall_i and Flush_i.
REQ-026 SHALL resume normal loading on the first edge with rst_i=1; reset asserted mid-stall discards held contents.

Structure
REQ-027 SHALL take ALUOp encodings, control-bit bundle layout and the bubble/reset constant from the shared pipeline package.
REQ-028 SHALL implement the data path as instances of one generic enable/clear register sub-module, pipe_reg (enable=~Stall_i, clear=Flush_i or reset).
REQ-029 SHALL keep the bubble counter in this module, outside pipe_reg.

Verification
REQ-030 Reset: rst_i=0 one edge with Stall_i=1, Flush_i=1 -> all outputs 0, BubbleCnt_o=0.
REQ-031 Load: Valid_i=1, RegWrite_i=1, RDAddr_i=5, RS1Data_i=32'h0000_1234 -> next edge RegWrite_o=1, RDAddr_o=5, RS1Data_o=32'h0000_1234, Valid_o=1.
REQ-032 x0: RegWrite_i=1, RDAddr_i=0, Valid_i=1 -> RegWrite_o=0, Valid_o=1.
REQ-033 Stall then flush: load RS2Data_i=32'hDEAD_BEEF; Stall_i=1 and Flush_i=1 for 3 edges -> RS2Data_o holds 32'hDEAD_BEEF, BubbleCnt_o unchanged; Stall_i=0 with Flush_i=1 -> bubble, BubbleCnt_o+1.
REQ-034 Saturation: CNT_W=4, 17 consecutive flush edges -> BubbleCnt_o=4'hF, stays 4'hF.
REQ-035 Invalid input: Valid_i=0, MemWrite_i=1, Flush_i=0 -> MemWrite_o=0, Valid_o=0, BubbleCnt_o unchanged.
